// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: FSM state type and counter sizing helper
// used by the sequential multiplier and the restoring divider.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Width of a down-counter that must hold the value w itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_multiply.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Produces a 2W-bit product W cycles after an accepted start.
// Optional macro MULTIPLY_OVERFLOW_EN adds the overflow output (product
// does not fit in W bits), registered alongside p.
//
// state | meaning
// IDLE  | waiting for start, no result yet
// RUN   | iterating one multiplier bit per cycle, busy=1
// DONE  | result valid in p, done=1, start relaunches
module seq_multiply
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done
`ifdef MULTIPLY_OVERFLOW_EN
    ,
    output logic           overflow
`endif
);

    localparam int CW = cnt_w(W);

    mul_state_t    state;
    mul_state_t    state_next;

    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W:0]    acc;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last;
    logic [W:0]    sum;
    logic [W:0]    acc_next;
    logic [W-1:0]  mplier_next;

    // A start is honoured whenever no multiplication is in flight.
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(1));

    // One add-and-shift step; the carry bit of acc keeps the sum exact.
    always_comb begin
        sum = acc;
        if (mplier[0]) begin
            sum = acc + {1'b0, mcand};
        end
        {acc_next, mplier_next} = {sum, mplier} >> 1;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and decoded status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and the iterating datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= x;
            mplier <= y;
            acc    <= '0;
            cnt    <= CW'(W);
        end else if (state == RUN) begin
            acc    <= acc_next;
            mplier <= mplier_next;
            cnt    <= cnt - CW'(1);
        end
    end

    // Product register: updated only on the final iteration.
    always_ff @(posedge clock) begin
        if (reset) begin
            p <= '0;
        end else if (last) begin
            p <= {acc_next[W-1:0], mplier_next};
        end
    end

`ifdef MULTIPLY_OVERFLOW_EN
    // Overflow flag tracks the upper product half; cleared on a new start.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (accept) begin
            overflow <= 1'b0;
        end else if (last) begin
            overflow <= |acc_next[W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply (W=8); reference is plain x*y.
module tb_seq_multiply;

    localparam int W = 8;

    logic           clock;
    logic           reset;
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;
`ifdef MULTIPLY_OVERFLOW_EN
    logic           overflow;
`endif

    int total = 0;
    int bad   = 0;

    seq_multiply #(.W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .y        (y),
        .p        (p),
        .busy     (busy),
        .done     (done)
`ifdef MULTIPLY_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] ref_mul(input int a, input int b);
        return (2*W)'(a * b);
    endfunction

    // Drive a one-cycle start pulse; returns at the negedge after edge 0.
    task automatic launch(input int a, input int b);
        @(negedge clock);
        x     = W'(a);
        y     = W'(b);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Count cycles until done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 4*W) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clock);
        total++;
        if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: p=%0d busy=%b done=%b, want 0/0/0", p, busy, done);
        end
`ifdef MULTIPLY_OVERFLOW_EN
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_overflow: got %b want 0", overflow);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int stray = 0;
        launch(13, 11);
        for (int i = 1; i < W; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) stray++;
            @(negedge clock);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL basic_busy: %0d cycles without busy, want 0", stray);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || p !== 16'd143) begin
            bad++;
            $display("FAIL basic_result: done=%b busy=%b p=%0d, want 1/0/143", done, busy, p);
        end
        repeat (5) @(negedge clock);
        total++;
        if (done !== 1'b1 || p !== 16'd143) begin
            bad++;
            $display("FAIL basic_hold: done=%b p=%0d, want 1/143", done, p);
        end
    endtask

    task automatic test_corners();
        int a_tab[3] = '{255, 0, 15};
        int b_tab[3] = '{255, 200, 17};
        int cycles;
        for (int k = 0; k < 3; k++) begin
            launch(a_tab[k], b_tab[k]);
            wait_done(cycles);
            total++;
            if (cycles != W || p !== ref_mul(a_tab[k], b_tab[k])) begin
                bad++;
                $display("FAIL corner_%0d: cycles=%0d p=%0d, want %0d/%0d", k, cycles, p, W, ref_mul(a_tab[k], b_tab[k]));
            end
`ifdef MULTIPLY_OVERFLOW_EN
            total++;
            if (overflow !== (ref_mul(a_tab[k], b_tab[k]) >= 16'(256))) begin
                bad++;
                $display("FAIL corner_ovf_%0d: got %b", k, overflow);
            end
`endif
        end
    endtask

    task automatic test_random();
        int a, b, cycles;
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            launch(a, b);
            x = W'($urandom);
            y = W'($urandom);
            wait_done(cycles);
            total++;
            if (cycles != W || p !== ref_mul(a, b)) begin
                bad++;
                $display("FAIL random_%0d: %0d*%0d cycles=%0d p=%0d, want %0d/%0d", k, a, b, cycles, p, W, ref_mul(a, b));
            end
`ifdef MULTIPLY_OVERFLOW_EN
            total++;
            if (overflow !== (ref_mul(a, b) >= 16'(256))) begin
                bad++;
                $display("FAIL random_ovf_%0d: got %b", k, overflow);
            end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int cycles;
        launch(3, 5);
        @(negedge clock);
        x     = 8'd9;
        y     = 8'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        x     = 8'd77;
        y     = 8'd31;
        wait_done(cycles);
        total++;
        if (cycles != W - 2 || p !== 16'd15) begin
            bad++;
            $display("FAIL ignore_start: cycles=%0d p=%0d, want %0d/15", cycles, p, W - 2);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        launch(100, 100);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b p=%0d, want 0/0/0", busy, done, p);
        end
        launch(7, 6);
        wait_done(cycles);
        total++;
        if (cycles != W || p !== 16'd42) begin
            bad++;
            $display("FAIL restart: cycles=%0d p=%0d, want %0d/42", cycles, p, W);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        @(negedge clock);
        x     = 8'd2;
        y     = 8'd3;
        start = 1'b1;
        @(negedge clock);
        x     = 8'd4;
        y     = 8'd5;
        wait_done(cycles);
        total++;
        if (cycles != W || p !== 16'd6) begin
            bad++;
            $display("FAIL b2b_first: cycles=%0d p=%0d, want %0d/6", cycles, p, W);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || p !== 16'd6) begin
            bad++;
            $display("FAIL b2b_relaunch: done=%b busy=%b p=%0d, want 0/1/6", done, busy, p);
        end
        wait_done(cycles);
        start = 1'b0;
        total++;
        if (cycles != W || p !== 16'd20) begin
            bad++;
            $display("FAIL b2b_second: cycles=%0d p=%0d, want %0d/20", cycles, p, W);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop: done=%b busy=%b, want 1/0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
